// File: rtl/demux_dest_fifo_pkg.sv
// Shared encodings for the destination demux.
// Contents: global state encodings, destination field width, and the
// RUN/ERR overflow FSM state type.
package demux_dest_fifo_pkg;

  localparam logic [3:0] ST_INIT   = 4'b0001;
  localparam logic [3:0] ST_ACTIVE = 4'b0010;
  localparam int         DEST_W    = 2;
  localparam int         NUM_LANES = 4;

  typedef enum logic {
    FSM_RUN = 1'b0,
    FSM_ERR = 1'b1
  } fsm_e;

endpackage

// File: rtl/demux_dest_fifo_fifo_sync.sv
// Single-clock FIFO for one destination lane.
// Ports:
//   clk, reset      clock and async active-high reset
//   flush           synchronous clear of pointers and count
//   push, pop       qualified write/read strobes (the caller gates them)
//   din             write word
//   dout            head word (combinational from storage)
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
module fifo_sync #(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr, rptr;

  // Pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; count guards every read.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/demux_dest_fifo.sv
// Destination demux: routes each incoming word by its top DEST_W bits into
// one of four FIFOs, serves per-lane pops with a registered head word, and
// flags overflow as a sticky error.
// Ports:
//   clk, reset            clock, async active-high reset
//   state                 one-hot global state (INIT / ACTIVE / other = HOLD)
//   valid_in, data_in     incoming word from the mux
//   pop                   per-lane read request
//   data_out0..3          registered head word per lane
//   valid_out             per-lane 1-cycle pulse qualifying data_outN
//   empty, full           per-lane occupancy flags
//   almost_full/empty     per-lane threshold flags
//   pause_out             backpressure to the mux (any lane almost full)
//   error_out             sticky overflow flag
//   drop_cnt              discarded-push counter
// Build option: DEMUX_DROP_CNT_EN enables the saturating drop counter;
// without it drop_cnt is tied to zero.
module demux_dest_fifo
  import demux_dest_fifo_pkg::*;
#(
  parameter int DATA_W     = 10,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic [3:0]        pop,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic [3:0]        valid_out,
  output logic [3:0]        empty,
  output logic [3:0]        full,
  output logic [3:0]        almost_full,
  output logic [3:0]        almost_empty,
  output logic              pause_out,
  output logic              error_out,
  output logic [7:0]        drop_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [NUM_LANES-1:0][DATA_W-1:0] head, dout_q;
  logic [NUM_LANES-1:0][CW-1:0]     count;
  logic [NUM_LANES-1:0]             push_ok, pop_ok;
  logic [DEST_W-1:0]                dest;
  logic                             active, init, push_req, overflow, drop_ev;
  fsm_e                             fsm_q, fsm_d;

  assign active   = (state == ST_ACTIVE);
  assign init     = (state == ST_INIT);
  assign dest     = data_in[DATA_W-1 -: DEST_W];
  assign push_req = active & valid_in;

  // A same-cycle pop frees a slot, so a push to a full lane is only an
  // overflow when that lane is not also popping.
  assign overflow = push_req & (fsm_q == FSM_RUN) & full[dest] & ~pop[dest];
  assign drop_ev  = push_req & ((fsm_q == FSM_ERR) | overflow);

  always_comb begin
    push_ok = '0;
    if (push_req && fsm_q == FSM_RUN && !overflow) push_ok[dest] = 1'b1;
  end

  // Pops on empty lanes are dropped here, so push+pop on an empty lane
  // takes the push only (no bypass).
  assign pop_ok = {NUM_LANES{active}} & pop & ~empty;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    fifo_sync #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (init),
      .push  (push_ok[i]),
      .pop   (pop_ok[i]),
      .din   (data_in),
      .dout  (head[i]),
      .count (count[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    assign almost_full[i]  = (count[i] >= CW'(AF_THRESH));
    assign almost_empty[i] = (count[i] <= CW'(AE_THRESH));

    always_ff @(posedge clk or posedge reset) begin
      if (reset)          dout_q[i] <= '0;
      else if (pop_ok[i]) dout_q[i] <= head[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid_out <= '0;
    else       valid_out <= pop_ok;
  end

  assign data_out0 = dout_q[0];
  assign data_out1 = dout_q[1];
  assign data_out2 = dout_q[2];
  assign data_out3 = dout_q[3];
  assign pause_out = |almost_full;

  // Overflow FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= FSM_RUN;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_RUN: if (overflow) fsm_d = FSM_ERR;
      FSM_ERR: fsm_d = FSM_ERR;
      default: fsm_d = FSM_RUN;
    endcase
    if (init) fsm_d = FSM_RUN;
  end

  assign error_out = (fsm_q == FSM_ERR);

`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         drop_q <= '0;
    else if (init)                     drop_q <= '0;
    else if (drop_ev && drop_q != '1)  drop_q <= drop_q + 8'd1;
  end
  assign drop_cnt = drop_q;
`else
  logic unused_drop;
  assign unused_drop = drop_ev;
  assign drop_cnt    = 8'h00;
`endif

endmodule
